// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer
//
// Steps an NTT butterfly datapath through all log2(N) stages of one transform.
// On an accepted start it latches the size (log_n = MIN_LOG_N + cfg) and the
// direction. For each stage it meters LANES-wide issue beats until N/2
// butterflies are issued. It then waits for all of them to retire through a
// DELAY-deep pipeline, raises the new-stage trigger, and moves to the next
// stride.
//
// Ports:
//   clk, i_resetn          clock, asynchronous active-low reset
//   i_point_configuration  size select, sampled on an accepted start
//   i_inverse              0: stride N/2 -> 1, 1: stride 1 -> N/2
//   i_start                start pulse, honoured only when idle
//   i_clear                synchronous abort back to idle
//   i_working              datapath consumed a beat (counted only with o_issue_en)
//   o_issue_en             a beat can be accepted this cycle
//   o_calc_idx             butterfly index of the current beat within the stage
//   o_stride               current stage stride
//   o_num_groups           N / (2 * stride)
//   o_stage_idx            current stage, 0 .. log_n-1
//   o_new_stage_trigger    all butterflies of the stage have retired
//   o_busy                 transform in progress
//   o_done                 final stage trigger
module ntt_stage_sequencer #(
    parameter int unsigned MIN_LOG_N = 3,
    parameter int unsigned CFG_W     = 3,
    parameter int unsigned LANES     = 4,
    parameter int unsigned DELAY     = 6,
    localparam int unsigned MAX_LOG_N = MIN_LOG_N + (1 << CFG_W) - 1
) (
    input  logic                 clk,
    input  logic                 i_resetn,
    input  logic [CFG_W-1:0]     i_point_configuration,
    input  logic                 i_inverse,
    input  logic                 i_start,
    input  logic                 i_clear,
    input  logic                 i_working,
    output logic                 o_issue_en,
    output logic [MAX_LOG_N-1:0] o_calc_idx,
    output logic [MAX_LOG_N-1:0] o_stride,
    output logic [MAX_LOG_N-1:0] o_num_groups,
    output logic [3:0]           o_stage_idx,
    output logic                 o_new_stage_trigger,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned LogW = $clog2(MAX_LOG_N + 1);
    localparam logic [MAX_LOG_N-1:0] LanesInc = MAX_LOG_N'(LANES);
    localparam logic [MAX_LOG_N-1:0] One      = MAX_LOG_N'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    state_e               state_q, state_d;
    logic [LogW-1:0]      log_n_q, log_n_d;
    logic                 inverse_q, inverse_d;
    logic [MAX_LOG_N-1:0] stride_q, stride_d;
    logic [3:0]           stage_q, stage_d;
    logic [MAX_LOG_N-1:0] issue_cnt_q, issue_cnt_d;
    logic [MAX_LOG_N-1:0] retire_cnt_q, retire_cnt_d;
    logic [DELAY-1:0]     sr_q, sr_d;

    logic [MAX_LOG_N-1:0] half;
    logic [LogW-1:0]      log_n_new;
    logic [LogW-1:0]      group_log;
    logic                 issue_en;
    logic                 accept;
    logic                 trigger;
    logic                 last_stage;
    logic                 go_idle;

    always_comb begin
        // Only meaningful while busy; log_n_q is at least MIN_LOG_N then.
        half       = One << (log_n_q - LogW'(1));
        log_n_new  = LogW'(MIN_LOG_N) + LogW'(i_point_configuration);
        issue_en   = (state_q == StIssue) && (issue_cnt_q < half);
        accept     = issue_en && i_working;
        trigger    = (state_q == StDrain) && (retire_cnt_q == half);
        last_stage = (stage_q == 4'(log_n_q - LogW'(1)));
        // Forward starts with one group and doubles; inverse starts with N/2 groups.
        group_log  = inverse_q ? (log_n_q - LogW'(1) - LogW'(stage_q)) : LogW'(stage_q);
    end

    always_comb begin
        state_d      = state_q;
        log_n_d      = log_n_q;
        inverse_d    = inverse_q;
        stride_d     = stride_q;
        stage_d      = stage_q;
        issue_cnt_d  = accept ? issue_cnt_q + LanesInc : issue_cnt_q;
        retire_cnt_d = sr_q[DELAY-1] ? retire_cnt_q + LanesInc : retire_cnt_q;
        sr_d         = '0;
        sr_d[0]      = accept;
        for (int i = 1; i < int'(DELAY); i++) begin
            sr_d[i] = sr_q[i-1];
        end
        go_idle = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d      = StIssue;
                    log_n_d      = log_n_new;
                    inverse_d    = i_inverse;
                    stride_d     = i_inverse ? One : (One << (log_n_new - LogW'(1)));
                    stage_d      = 4'd0;
                    issue_cnt_d  = '0;
                    retire_cnt_d = '0;
                    sr_d         = '0;
                end
            end
            StIssue: begin
                if (issue_cnt_d >= half) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (trigger) begin
                    if (last_stage) begin
                        go_idle = 1'b1;
                    end else begin
                        state_d      = StIssue;
                        stride_d     = inverse_q ? (stride_q << 1) : (stride_q >> 1);
                        stage_d      = stage_q + 4'd1;
                        issue_cnt_d  = '0;
                        retire_cnt_d = '0;
                    end
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        // Abort wins over start and trigger; in-flight beats are dropped.
        if (i_clear || go_idle) begin
            state_d      = StIdle;
            log_n_d      = '0;
            inverse_d    = 1'b0;
            stride_d     = '0;
            stage_d      = 4'd0;
            issue_cnt_d  = '0;
            retire_cnt_d = '0;
            sr_d         = '0;
        end
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q      <= StIdle;
            log_n_q      <= '0;
            inverse_q    <= 1'b0;
            stride_q     <= '0;
            stage_q      <= 4'd0;
            issue_cnt_q  <= '0;
            retire_cnt_q <= '0;
            sr_q         <= '0;
        end else begin
            state_q      <= state_d;
            log_n_q      <= log_n_d;
            inverse_q    <= inverse_d;
            stride_q     <= stride_d;
            stage_q      <= stage_d;
            issue_cnt_q  <= issue_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            sr_q         <= sr_d;
        end
    end

    always_comb begin
        o_busy              = (state_q != StIdle);
        o_issue_en          = issue_en;
        o_calc_idx          = issue_cnt_q;
        o_stride            = stride_q;
        o_num_groups        = o_busy ? (One << group_log) : '0;
        o_stage_idx         = stage_q;
        o_new_stage_trigger = trigger;
        o_done              = trigger && last_stage;
    end

endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
Parametrised stage/stride sequencer for the NTT butterfly datapath. It latches a point-size configuration and direction on a start pulse, then steps through all log2(N) stages. For each stage it meters butterfly issue in LANES-wide beats and tracks their retirement through a DELAY-deep pipeline. It emits the per-stage stride, group count and stage index, a new-stage trigger and a done pulse. Forward mode halves the stride each stage; inverse mode doubles it.

Parameters:
MIN_LOG_N, 3, log2 of the smallest supported transform (cfg 0 gives N = 2^MIN_LOG_N).
CFG_W, 3, width of the point-configuration field. log_n = MIN_LOG_N + cfg. MAX_LOG_N = MIN_LOG_N + 2^CFG_W - 1 (default 10, i.e. N = 1024).
LANES, 4, butterflies retired per accepted issue beat. Power of 2, at most 2^(MIN_LOG_N-1).
DELAY, 6, issue-to-retire pipeline depth in cycles. Must be at least 1.

Ports:
clk  in  1  clock
i_resetn  in  1  asynchronous active-low reset
i_point_configuration  in  CFG_W  size select, sampled only on an accepted start
i_inverse  in  1  0 = forward (stride N/2 down to 1); 1 = inverse (stride 1 up to N/2); sampled with start
i_start  in  1  start pulse; accepted only in IDLE
i_clear  in  1  synchronous abort to IDLE
i_working  in  1  datapath consumed one LANES-wide beat this cycle; counted only when o_issue_en=1
o_issue_en  out  1  sequencer will accept a beat this cycle
o_calc_idx  out  MAX_LOG_N  butterfly index of the current beat within the stage (0, LANES, 2*LANES, ...)
o_stride  out  MAX_LOG_N  current stage stride (also calcs per group)
o_num_groups  out  MAX_LOG_N  N/(2*stride)
o_stage_idx  out  4  current stage, 0..log_n-1
o_new_stage_trigger  out  1  one-cycle pulse when all butterflies of the stage have retired
o_busy  out  1  high in ISSUE and DRAIN
o_done  out  1  one-cycle pulse coincident with the final stage's trigger

Behaviour:
- Reset (async, i_resetn=0): state IDLE; all outputs and counters 0; retire shift register flushed.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when i_start=1. Latch log_n and i_inverse.
  - Load the first stage: stride = N/2 (forward) or 1 (inverse); stage_idx = 0; issue_cnt = retire_cnt = 0.
- Issue:
  - o_issue_en = (state==ISSUE) && (issue_cnt < N/2). It is combinational from registers.
  - A beat is accepted when i_working && o_issue_en. On acceptance, issue_cnt += LANES.
  - o_calc_idx = issue_cnt before the increment.
  - i_working while o_issue_en=0 is ignored and is not counted.
- ISSUE -> DRAIN when issue_cnt reaches N/2.
- Retire tracking:
  - Each accepted beat pushes a 1 into a DELAY-deep shift register; other cycles push a 0.
  - Each 1 leaving the register adds LANES to retire_cnt.
  - A beat accepted in cycle t advances retire_cnt at the end of cycle t+DELAY.
- Stage trigger:
  - o_new_stage_trigger = (state==DRAIN) && (retire_cnt == N/2). It is a combinational compare of registered values.
  - On the trigger, if this is not the last stage: stride = stride>>1 (forward) or <<1 (inverse); stage_idx += 1; issue_cnt = retire_cnt = 0; state -> ISSUE.
  - The first beat of the next stage can be accepted the cycle after the trigger. No beat is accepted in the trigger cycle.
- Completion:
  - On the trigger with stage_idx == log_n-1: o_done=1 in that same cycle.
  - Next cycle: state IDLE; all outputs return to 0.
- o_num_groups is recomputed from the latched log_n and the current stride. It is valid whenever o_busy=1.
- Stage period with i_working held high: N/(2*LANES) + DELAY + 1 cycles.
- i_clear (sampled on the clock edge):
  - Forces IDLE and zeroes outputs and counters; flushes the shift register.
  - It takes priority over i_start and the trigger in the same cycle.
  - Beats still in flight at the abort are discarded.
- Input changes:
  - i_start outside IDLE is ignored.
  - i_point_configuration and i_inverse changes after start have no effect until the next start.
- Widths: all counts are unsigned MAX_LOG_N bits. N/2 at most 2^(MAX_LOG_N-1), so no overflow is possible.

Test Plan:
- Reset mid-ISSUE (cfg=7, i_resetn low for 1 cycle, async to clk) -> all outputs 0 immediately; no trigger when i_resetn deasserts.
- cfg=0, forward, start at cycle 0, i_working held high, LANES=4, DELAY=6:
  - o_stride = 4, 2, 1; o_num_groups = 1, 2, 4; o_stage_idx = 0, 1, 2.
  - Beats accepted at cycles 1, 9, 17; triggers at cycles 8, 16, 24.
  - o_done at cycle 24; o_busy=0 at cycle 25.
- cfg=0, inverse, same stimulus -> o_stride = 1, 2, 4; o_num_groups = 4, 2, 1; trigger timing identical to the forward case.
- cfg=7, forward, i_working held high:
  - 128 beats per stage; o_calc_idx = 0..508 in steps of 4.
  - Triggers at cycles 135, 270, ..., 1350 (10 stages); o_done at 1350.
- cfg=1 with i_working toggled 1/0 -> 2 beats per stage take 3 cycles (beats accepted at cycles 1 and 3, no beat in cycle 2); first trigger at cycle 10. Idle cycles are not counted.
- cfg=3, assert i_clear in stage 2 while beats are in flight -> IDLE next cycle, outputs 0, no trigger or done. A new i_start the next cycle with cfg=0 runs the clean cfg=0 sequence from the forward test above.
